avg_pool_mc: RTL and testbench
==============================

Name: avg_pool_mc

Overview:
- Multi-channel, runtime-configurable pooling unit for the attention datapath.
- Reduces a stream of CH parallel signed lanes over a window of 2^len_log accepted samples.
- Each lane produces either the rounded mean (average mode) or the maximum (max mode).
- Parametrised successor of the single-lane fixed-window average pool; adds lanes, runtime window length, max mode, abort and back-to-back windows.

Parameters:
- CH, 4, number of parallel lanes.
- DW, 16, lane width (two's complement signed).
- MAX_LOG, 3, log2 of largest supported window (max window 8).
- LW, 2, width of len_log port; must satisfy 2^LW > MAX_LOG.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- en  in  1  sample valid; i_avg accepted on every rising clk edge with en=1.
- i_avg  in  CH*DW  packed lane samples; lane k = bits [k*DW +: DW].
- len_log  in  LW  window length selector, window = 2^len_log samples.
- mode  in  1  0 = average, 1 = max.
- clr  in  1  abort the current window; discards partial results.
- o_avg  out  CH*DW  pooled result per lane; held until the next result.
- end_avg  out  1  one-cycle pulse; o_avg is updated in the same cycle.
- busy  out  1  high while a window is partially accumulated.

Behaviour:
- Reset (rst=1 at clk edge): o_avg=0, end_avg=0, busy=0, sample count=0, accumulators=0, state IDLE. Reset takes effect mid-window and discards partial data.
- Effective length: L = min(len_log, MAX_LOG). L is latched, together with mode, on the first accepted sample of a window. Changes to len_log or mode during ACC are ignored until the next window.
- States:
  - IDLE: waiting for the first sample. On en: load acc_k = sext(sample_k), or max_k = sample_k in max mode; count=1.
    - If L=0 the window completes immediately: result registered, end_avg next cycle, state stays IDLE.
    - Otherwise go to ACC with busy=1.
  - ACC: on each en, acc_k += sext(sample_k) or max_k = max(max_k, sample_k) (signed compare), and count++.
    - When the sample with count = 2^L-1 arrives, the final value is computed from acc plus the current sample and registered to o_avg.
    - end_avg pulses on the following cycle; state returns to IDLE and busy=0.
  - en=0 cycles are bubbles: no state change and no timeout.
- Latency: end_avg and the new o_avg appear exactly 1 cycle after the clk edge that accepts the last sample.
- Back-to-back: a sample with en=1 in the cycle immediately after a last sample starts a new window with no bubble. This cycle coincides with the end_avg pulse of the previous window.
- Arithmetic:
  - Accumulator width is DW+MAX_LOG, sign-extended; it cannot overflow.
  - Average = (acc + 2^(L-1)) >>> L for L>0, i.e. round half toward +inf with arithmetic shift; for L=0 it is the sample itself.
  - Result is truncated to DW. It is always within the input range, so no saturation is needed.
- clr: at a clk edge it forces IDLE, busy=0 and count=0; o_avg holds its previous value and end_avg=0.
  - clr together with en: clr wins and the sample is dropped.
  - clr in the same cycle as a last sample: the window is aborted and no end_avg is produced.
- end_avg is never high for two consecutive cycles unless L=0 and en is held high. In that case each accepted sample gives one pulse.
- Lanes are fully independent; there is no cross-lane carry.

Test Plan:
- Defaults (CH=4, DW=16, MAX_LOG=3), len_log=2, mode=0. Lane0 stream 1,2,3,4; lane1 stream -1,-2,-3,-4 → one end_avg pulse 1 cycle after the 4th sample; lane0=3 (10+2>>2), lane1=-2 ((-10+2)>>>2); busy high from the 1st sample through the 4th.
- len_log=3, mode=1. Lane0 samples -5,7,-32768,32767,0,1,2,3 interleaved with en=0 bubbles → lane0 max=32767; end_avg only after the 8th accepted sample; bubbles do not advance the count.
- len_log=1, two windows with en held high: samples 4,6 then 9,10 → end_avg pulses at cycles t+2 and t+4 with o_avg=5, then 10 (19+1>>1); the second window's first sample is accepted during the first end_avg pulse.
- len_log=2, two samples accepted, then clr asserted together with en → no end_avg, busy=0, o_avg retains its prior value. A fresh 4-sample window of 8s then gives 8.
- Mid-window rst after 3 of 4 samples → all outputs 0 in the next cycle; a subsequent 4-sample window of 1s gives o_avg lane values of 1.
- len_log=3 with MAX_LOG=2 (clamp), and len_log changed to 0 mid-window → window completes after 4 samples; the latched L is used, and the new len_log applies only to the next window (pass-through, 1-cycle latency).

Source files
------------

// File: rtl/avg_pool_mc.sv
// avg_pool_mc: multi-lane pooling unit.
// Reduces CH signed lanes over a window of 2^L accepted samples, where
// L = min(len_log, MAX_LOG) is captured with mode on the first sample of a
// window. Each lane yields the rounded mean (mode=0) or the signed maximum
// (mode=1). The result register and end_avg pulse update on the clock edge
// that accepts the last sample of the window.
//
// Handshake: there is no backpressure. A sample is taken on every rising
// clk edge where en=1 and clr=0. end_avg is a single-cycle strobe that marks
// a fresh o_avg; o_avg holds until the next completed window.
module avg_pool_mc #(
    parameter int CH      = 4,
    parameter int DW      = 16,
    parameter int MAX_LOG = 3,
    parameter int LW      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CH*DW-1:0] i_avg,
    input  logic [LW-1:0]    len_log,
    input  logic             mode,
    input  logic             clr,
    output logic [CH*DW-1:0] o_avg,
    output logic             end_avg,
    output logic             busy
);

    // Accumulator holds up to 2^MAX_LOG samples without overflow.
    localparam int AW = DW + MAX_LOG;
    localparam int CW = MAX_LOG + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [LW-1:0]      l_q, l_d;
    logic               mode_q, mode_d;
    logic [CW-1:0]      count_q, count_d;
    logic signed [AW-1:0] acc_q [CH];
    logic signed [AW-1:0] acc_d [CH];
    logic [CH*DW-1:0]   o_avg_q, o_avg_d;
    logic               end_q, end_d;

    logic [LW-1:0]      l_eff;
    logic [LW-1:0]      cur_l;
    logic               cur_mode;
    logic [CW-1:0]      win_m1;
    logic               last;
    logic signed [AW:0] rnd;
    logic signed [AW-1:0] samp   [CH];
    logic signed [AW-1:0] comb_v [CH];
    logic signed [AW:0]   sum_v  [CH];

    // Window parameters: live inputs in IDLE, latched copies inside a window.
    always_comb begin
        l_eff    = (len_log > LW'(MAX_LOG)) ? LW'(MAX_LOG) : len_log;
        cur_l    = (state_q == S_IDLE) ? l_eff : l_q;
        cur_mode = (state_q == S_IDLE) ? mode : mode_q;
        win_m1   = (CW'(1) << cur_l) - CW'(1);
        // count_q is zero in IDLE, so an L=0 window completes on its first sample.
        last     = (count_q == win_m1);
        rnd      = (cur_l == '0) ? '0 : ((AW+1)'(1) << (cur_l - LW'(1)));
    end

    // Per-lane combine of the running value with the current sample.
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            samp[k] = {{MAX_LOG{i_avg[k*DW+DW-1]}}, i_avg[k*DW +: DW]};
            if (state_q == S_IDLE) begin
                comb_v[k] = samp[k];
            end else if (cur_mode) begin
                comb_v[k] = (samp[k] > acc_q[k]) ? samp[k] : acc_q[k];
            end else begin
                comb_v[k] = acc_q[k] + samp[k];
            end
            // One extra bit keeps the rounding add exact before the shift.
            sum_v[k] = {comb_v[k][AW-1], comb_v[k]} + rnd;
        end
    end

    // Next-state, accumulator and result logic; clr overrides a sample.
    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        mode_d  = mode_q;
        count_d = count_q;
        o_avg_d = o_avg_q;
        end_d   = 1'b0;
        for (int k = 0; k < CH; k++) begin
            acc_d[k] = acc_q[k];
        end
        if (clr) begin
            state_d = S_IDLE;
            count_d = '0;
        end else if (en) begin
            if (state_q == S_IDLE) begin
                l_d    = l_eff;
                mode_d = mode;
            end
            for (int k = 0; k < CH; k++) begin
                acc_d[k] = comb_v[k];
            end
            if (last) begin
                state_d = S_IDLE;
                count_d = '0;
                end_d   = 1'b1;
                for (int k = 0; k < CH; k++) begin
                    o_avg_d[k*DW +: DW] = cur_mode ? DW'(comb_v[k])
                                                   : DW'(sum_v[k] >>> cur_l);
                end
            end else begin
                state_d = S_ACC;
                count_d = count_q + CW'(1);
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            l_q     <= '0;
            mode_q  <= 1'b0;
            count_q <= '0;
            o_avg_q <= '0;
            end_q   <= 1'b0;
            for (int k = 0; k < CH; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            o_avg_q <= o_avg_d;
            end_q   <= end_d;
            for (int k = 0; k < CH; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    assign o_avg   = o_avg_q;
    assign end_avg = end_q;
    assign busy    = (state_q == S_ACC);

endmodule

// File: tb/tb_avg_pool_mc.sv
// tb_avg_pool_mc: directed plus random stimulus on two instances
// (MAX_LOG=3 and MAX_LOG=2) sharing inputs, checked each cycle against a
// window-list reference model.
module tb_avg_pool_mc;

    localparam int CH = 4;
    localparam int DW = 16;
    localparam int LW = 2;
    localparam int W  = CH * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          clr;
    logic          mode;
    logic [LW-1:0] len_log;
    logic [W-1:0]  i_avg;
    logic [W-1:0]  o_avg1, o_avg2;
    logic          end1, end2, busy1, busy2;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model state, index 0 = MAX_LOG 3 instance, 1 = MAX_LOG 2.
    int max_log [2];
    int m_o     [2][CH];
    bit m_end   [2];
    bit m_busy  [2];
    int m_L     [2];
    bit m_mode  [2];
    int win_s   [2][CH][8];
    int win_n   [2];

    // Clock
    always #5 clk = ~clk;

    avg_pool_mc #(.CH(CH), .DW(DW), .MAX_LOG(3), .LW(LW)) dut (
        .clk(clk), .rst(rst), .en(en), .i_avg(i_avg), .len_log(len_log),
        .mode(mode), .clr(clr), .o_avg(o_avg1), .end_avg(end1), .busy(busy1)
    );

    avg_pool_mc #(.CH(CH), .DW(DW), .MAX_LOG(2), .LW(LW)) dut2 (
        .clk(clk), .rst(rst), .en(en), .i_avg(i_avg), .len_log(len_log),
        .mode(mode), .clr(clr), .o_avg(o_avg2), .end_avg(end2), .busy(busy2)
    );

    function automatic int lane_of(input logic [W-1:0] v, input int k);
        logic signed [DW-1:0] t;
        t = v[k*DW +: DW];
        return int'(t);
    endfunction

    function automatic logic [W-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [W-1:0] v;
        v[0*DW +: DW] = a[DW-1:0];
        v[1*DW +: DW] = b[DW-1:0];
        v[2*DW +: DW] = c[DW-1:0];
        v[3*DW +: DW] = d[DW-1:0];
        return v;
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int k = 0; k < CH; k++) begin
            case ($urandom_range(0, 7))
                0:       v[k*DW +: DW] = 16'h8000;
                1:       v[k*DW +: DW] = 16'h7fff;
                default: v[k*DW +: DW] = DW'($urandom);
            endcase
        end
        return v;
    endfunction

    // Mean with round-half-up via floor division, or max, over the stored window.
    function automatic int reduce(input int d, input int k);
        int n, s, mx, num, q;
        n = 1 << m_L[d];
        if (m_mode[d]) begin
            mx = win_s[d][k][0];
            for (int i = 1; i < n; i++) begin
                if (win_s[d][k][i] > mx) mx = win_s[d][k][i];
            end
            return mx;
        end
        s = 0;
        for (int i = 0; i < n; i++) s += win_s[d][k][i];
        num = s + n / 2;
        q = num / n;
        if ((num % n != 0) && (num < 0)) q = q - 1;
        return q;
    endfunction

    function automatic logic [W-1:0] exp_vec(input int d);
        logic [W-1:0] v;
        for (int k = 0; k < CH; k++) v[k*DW +: DW] = m_o[d][k][DW-1:0];
        return v;
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            m_end[d] = 1'b0;
            if (rst) begin
                m_busy[d] = 1'b0;
                win_n[d]  = 0;
                for (int k = 0; k < CH; k++) m_o[d][k] = 0;
            end else if (clr) begin
                m_busy[d] = 1'b0;
                win_n[d]  = 0;
            end else if (en) begin
                if (win_n[d] == 0) begin
                    m_L[d]    = (int'(len_log) > max_log[d]) ? max_log[d] : int'(len_log);
                    m_mode[d] = mode;
                end
                for (int k = 0; k < CH; k++) win_s[d][k][win_n[d]] = lane_of(i_avg, k);
                win_n[d]++;
                if (win_n[d] == (1 << m_L[d])) begin
                    for (int k = 0; k < CH; k++) m_o[d][k] = reduce(d, k);
                    m_end[d]  = 1'b1;
                    m_busy[d] = 1'b0;
                    win_n[d]  = 0;
                end else begin
                    m_busy[d] = 1'b1;
                end
            end
        end
    endtask

    task automatic chk_v(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk_v({tag, "_o_m3"},    o_avg1,      exp_vec(0));
        chk_i({tag, "_end_m3"},  int'(end1),  int'(m_end[0]));
        chk_i({tag, "_busy_m3"}, int'(busy1), int'(m_busy[0]));
        chk_v({tag, "_o_m2"},    o_avg2,      exp_vec(1));
        chk_i({tag, "_end_m2"},  int'(end2),  int'(m_end[1]));
        chk_i({tag, "_busy_m2"}, int'(busy2), int'(m_busy[1]));
    endtask

    // Drive one cycle, advance the model at the edge, check 1 time unit later.
    task automatic step(input bit e, input bit c, input logic [W-1:0] smp, input string tag);
        en    = e;
        clr   = c;
        i_avg = smp;
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    initial begin
        max_log[0] = 3;
        max_log[1] = 2;
        for (int d = 0; d < 2; d++) begin
            win_n[d] = 0; m_L[d] = 0; m_mode[d] = 1'b0;
            m_end[d] = 1'b0; m_busy[d] = 1'b0;
            for (int k = 0; k < CH; k++) m_o[d][k] = 0;
        end
        rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 1'b0; len_log = '0; i_avg = '0;

        // Reset
        step(1'b0, 1'b0, '0, "rst0");
        step(1'b1, 1'b0, rand_vec(), "rst1");
        rst = 1'b0;
        chk_v("rst_o", o_avg1, '0);

        // Average of 4: lane0 1..4, lane1 -1..-4
        len_log = 2'd2; mode = 1'b0;
        step(1'b1, 1'b0, pack4(1, -1, int'($urandom), int'($urandom)), "t1a");
        chk_i("t1_busy", int'(busy1), 1);
        step(1'b1, 1'b0, pack4(2, -2, int'($urandom), int'($urandom)), "t1b");
        step(1'b1, 1'b0, pack4(3, -3, int'($urandom), int'($urandom)), "t1c");
        step(1'b1, 1'b0, pack4(4, -4, int'($urandom), int'($urandom)), "t1d");
        chk_i("t1_lane0", lane_of(o_avg1, 0), 3);
        chk_i("t1_lane1", lane_of(o_avg1, 1), -2);
        chk_i("t1_end", int'(end1), 1);
        step(1'b0, 1'b0, rand_vec(), "t1e");

        // Max of 8 with bubbles (MAX_LOG=2 instance closes after 4)
        len_log = 2'd3; mode = 1'b1;
        begin
            int seq [8];
            seq = '{-5, 7, -32768, 32767, 0, 1, 2, 3};
            for (int i = 0; i < 8; i++) begin
                step(1'b1, 1'b0, pack4(seq[i], int'($urandom), int'($urandom), int'($urandom)), "t2s");
                if (i == 7) chk_i("t2_max", lane_of(o_avg1, 0), 32767);
                step(1'b0, 1'b0, rand_vec(), "t2b");
            end
        end
        chk_i("t2_max_m2", lane_of(o_avg2, 0), 3);

        // Back-to-back windows of 2
        len_log = 2'd1; mode = 1'b0;
        step(1'b1, 1'b0, pack4(4, 0, 0, 0), "t3a");
        step(1'b1, 1'b0, pack4(6, 0, 0, 0), "t3b");
        chk_i("t3_first", lane_of(o_avg1, 0), 5);
        step(1'b1, 1'b0, pack4(9, 0, 0, 0), "t3c");
        chk_i("t3_gap", int'(end1), 0);
        step(1'b1, 1'b0, pack4(10, 0, 0, 0), "t3d");
        chk_i("t3_second", lane_of(o_avg1, 0), 10);
        step(1'b0, 1'b0, '0, "t3e");

        // Abort with clr together with en, then a fresh window of 8s
        len_log = 2'd2;
        step(1'b1, 1'b0, rand_vec(), "t4a");
        step(1'b1, 1'b0, rand_vec(), "t4b");
        step(1'b1, 1'b1, rand_vec(), "t4clr");
        chk_i("t4_hold", lane_of(o_avg1, 0), 10);
        chk_i("t4_busy", int'(busy1), 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, pack4(8, 8, 8, 8), "t4w");
        chk_v("t4_eights", o_avg1, pack4(8, 8, 8, 8));

        // Reset mid-window, then a window of 1s
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rand_vec(), "t5a");
        rst = 1'b1;
        step(1'b1, 1'b0, rand_vec(), "t5rst");
        rst = 1'b0;
        chk_v("t5_zero", o_avg1, '0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, pack4(1, 1, 1, 1), "t5w");
        chk_v("t5_ones", o_avg1, pack4(1, 1, 1, 1));

        // Clamp on MAX_LOG=2 instance; len_log changed to 0 mid-window
        len_log = 2'd3;
        step(1'b1, 1'b0, pack4(10, 0, 0, 0), "t6a");
        step(1'b1, 1'b0, pack4(20, 0, 0, 0), "t6b");
        len_log = 2'd0;
        step(1'b1, 1'b0, pack4(30, 0, 0, 0), "t6c");
        chk_i("t6_no_end", int'(end2), 0);
        step(1'b1, 1'b0, pack4(40, 0, 0, 0), "t6d");
        chk_i("t6_clamp", lane_of(o_avg2, 0), 25);
        step(1'b1, 1'b0, pack4(50, 0, 0, 0), "t6e");
        chk_i("t6_pass", lane_of(o_avg2, 0), 50);
        chk_i("t6_pass_end", int'(end2), 1);
        step(1'b1, 1'b0, pack4(-7, 0, 0, 0), "t6f");
        chk_i("t6_pass2", lane_of(o_avg2, 0), -7);
        step(1'b0, 1'b1, '0, "t6clr");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            len_log = LW'($urandom_range(0, 3));
            mode    = 1'($urandom_range(0, 1));
            rst     = ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, rand_vec(), "rnd");
            rst = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
